// File: rtl/ecc_107_pkg.sv
// ecc_107_pkg: shared constants, the data-bit to codeword-position map and the
// FSM state type for the 107-bit SECDED write-path encoder.
//
// Codeword positions run 1..114. Power-of-two positions (1, 2, 4, ... 64) carry
// the Hamming bits p0..p6. Data bits fill every other position in ascending
// order. This mapping must stay identical to the read-path decoder's syndrome
// mapping.
package ecc_107_pkg;

  localparam int DATA_WIDTH   = 107;
  localparam int PARITY_WIDTH = 8;
  localparam int HAM_WIDTH    = PARITY_WIDTH - 1;
  localparam int CW_POSITIONS = DATA_WIDTH + HAM_WIDTH;   // 114
  localparam int INJ_WIDTH    = DATA_WIDTH + PARITY_WIDTH; // 115, {parity, data}

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_RETRY = 2'd1,
    ST_HALT  = 2'd2
  } fsm_state_e;

  // Returns the codeword position of data bit idx.
  // A position is a data slot when it is not a power of two.
  function automatic int data_pos(input int idx);
    int pos;
    int seen;
    pos  = 0;
    seen = -1;
    for (int p = 1; p <= CW_POSITIONS; p++) begin
      if ((p & (p - 1)) != 0) begin
        seen++;
        if (seen == idx) pos = p;
      end
    end
    return pos;
  endfunction

  // Selects the data bits that feed Hamming bit bit_i: those whose codeword
  // position has bit bit_i set.
  function automatic logic [DATA_WIDTH-1:0] ham_mask(input int bit_i);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int d = 0; d < DATA_WIDTH; d++) begin
      m[d] = ((data_pos(d) >> bit_i) & 1) != 0;
    end
    return m;
  endfunction

endpackage

// File: rtl/ecc_107_par_gen.sv
// ecc_107_par_gen: purely combinational SECDED parity generator for 107-bit data.
//
// Ports:
//   data   in  107  data word to encode
//   parity out 8    {overall, p6..p0}; overall = XOR of all data bits and p6..p0
module ecc_107_par_gen
  import ecc_107_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [PARITY_WIDTH-1:0] parity
);

  logic [HAM_WIDTH-1:0] ham;

  for (genvar i = 0; i < HAM_WIDTH; i++) begin : g_ham
    localparam logic [DATA_WIDTH-1:0] MASK = ham_mask(i);
    assign ham[i] = ^(data & MASK);
  end

  assign parity = {(^data) ^ (^ham), ham};

endmodule

// File: rtl/ecc_107_enc_fault_detc.sv
// ecc_107_enc_fault_detc: write-path SECDED encoder with redundant parity
// generation, compare, bounded retry and fatal halt.
//
// Pipeline: stage 1 (data_q/valid_q, loaded on in_valid && in_ready), stage 2
// (registered output). Two parity generators (u0, u1) encode data_q; a
// disagreement with ecc_fault_detc_en=1 blocks the stage-2 load and retries the
// same beat up to MAX_RETRY times before halting with ecc_fatal.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ecc_fault_detc_en        enables redundant compare and retry
//   bypass                   beat forced to parity 0 (captured with the beat)
//   in_valid/in_ready/data_in  input handshake and data
//   out_valid/out_ready/data_out/parity_out  registered codeword output
//   ecc_fault                one-cycle pulse per compare mismatch
//   ecc_fatal                sticky, set when retries are exhausted
//   fault_clr                clears fatal/counter/retry, drops held beat, back to RUN
//   fault_cnt                saturating mismatch count
//
// Build option: define ECC_ERR_INJ_EN to add inj_en/inj_mask, which XOR the
// mask into {parity_out, data_out} on the first stage-2 load of each inj_en
// assertion.
module ecc_107_enc_fault_detc
  import ecc_107_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ecc_fault_detc_en,
  input  logic                    bypass,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [PARITY_WIDTH-1:0] parity_out,
  output logic                    ecc_fault,
  output logic                    ecc_fatal,
  input  logic                    fault_clr,
`ifdef ECC_ERR_INJ_EN
  input  logic                    inj_en,
  input  logic [INJ_WIDTH-1:0]    inj_mask,
`endif
  output logic [CNT_WIDTH-1:0]    fault_cnt
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  fsm_state_e state_q, state_d;

  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    bypass_q, bypass_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic [PARITY_WIDTH-1:0] parity_out_q, parity_out_d;
  logic                    ecc_fault_q, ecc_fault_d;
  logic                    ecc_fatal_q, ecc_fatal_d;
  logic [CNT_WIDTH-1:0]    fault_cnt_q, fault_cnt_d;
  logic [RETRY_W-1:0]      retry_cnt_q, retry_cnt_d;
`ifdef ECC_ERR_INJ_EN
  logic                    inj_done_q, inj_done_d;
`endif

  logic [PARITY_WIDTH-1:0] par_u0, par_u1;
  logic                    mismatch;
  logic                    load2;
  logic                    accept;

  ecc_107_par_gen u0 (.data(data_q), .parity(par_u0));
  ecc_107_par_gen u1 (.data(data_q), .parity(par_u1));

  // Stage 2 may take the beat only while the FSM is comparing, the compare
  // passes, and the output register is free or draining this cycle.
  // fault_clr drops the held beat, so it also blocks the load.
  assign mismatch = valid_q && ecc_fault_detc_en && (par_u0 != par_u1);
  assign load2    = valid_q && !mismatch && !fault_clr
                    && (state_q == ST_RUN || state_q == ST_RETRY)
                    && (!out_valid_q || out_ready);
  assign in_ready = !rst && !fault_clr && (state_q == ST_RUN)
                    && (!valid_q || load2);
  assign accept   = in_valid && in_ready;

  // NOTE: every always_comb target gets a default first so no path leaves a
  // value unassigned; otherwise synthesis infers a latch.
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    bypass_d     = bypass_q;
    out_valid_d  = out_valid_q;
    data_out_d   = data_out_q;
    parity_out_d = parity_out_q;
    ecc_fault_d  = 1'b0;
    ecc_fatal_d  = ecc_fatal_q;
    fault_cnt_d  = fault_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    state_d      = state_q;
`ifdef ECC_ERR_INJ_EN
    inj_done_d   = inj_done_q && inj_en;
`endif

    // Stage 1
    if (load2) valid_d = 1'b0;
    if (accept) begin
      valid_d  = 1'b1;
      data_d   = data_in;
      bypass_d = bypass;
    end
    if (fault_clr) valid_d = 1'b0;

    // Stage 2; u0 is the reference result whether or not compare is enabled.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (load2) begin
      out_valid_d  = 1'b1;
      data_out_d   = data_q;
      parity_out_d = bypass_q ? '0 : par_u0;
`ifdef ECC_ERR_INJ_EN
      if (inj_en && !inj_done_q) begin
        {parity_out_d, data_out_d} = {parity_out_d, data_out_d} ^ inj_mask;
        inj_done_d = 1'b1;
      end
`endif
    end

    // Fault FSM
    if (fault_clr) begin
      ecc_fatal_d = 1'b0;
      fault_cnt_d = '0;
      retry_cnt_d = '0;
      state_d     = ST_RUN;
    end else begin
      if (mismatch && state_q != ST_HALT) begin
        ecc_fault_d = 1'b1;
        if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 1'b1;
      end
      case (state_q)
        ST_RUN: begin
          if (mismatch) begin
            retry_cnt_d = RETRY_W'(1);
            state_d     = ST_RETRY;
          end
        end
        ST_RETRY: begin
          if (mismatch) begin
            if (retry_cnt_q == RETRY_W'(MAX_RETRY)) begin
              ecc_fatal_d = 1'b1;
              state_d     = ST_HALT;
            end else begin
              retry_cnt_d = retry_cnt_q + 1'b1;
            end
          end else if (load2) begin
            retry_cnt_d = '0;
            state_d     = ST_RUN;
          end
        end
        ST_HALT: ;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      valid_q      <= 1'b0;
      data_q       <= '0;
      bypass_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      parity_out_q <= '0;
      ecc_fault_q  <= 1'b0;
      ecc_fatal_q  <= 1'b0;
      fault_cnt_q  <= '0;
      retry_cnt_q  <= '0;
`ifdef ECC_ERR_INJ_EN
      inj_done_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      bypass_q     <= bypass_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
      parity_out_q <= parity_out_d;
      ecc_fault_q  <= ecc_fault_d;
      ecc_fatal_q  <= ecc_fatal_d;
      fault_cnt_q  <= fault_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
`ifdef ECC_ERR_INJ_EN
      inj_done_q   <= inj_done_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign parity_out = parity_out_q;
  assign ecc_fault  = ecc_fault_q;
  assign ecc_fatal  = ecc_fatal_q;
  assign fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_ecc_107_enc_fault_detc.sv
// tb_ecc_107_enc_fault_detc: directed self-checking bench for the 107-bit
// SECDED encoder. Expected parities are hand-computed; a scoreboard queue
// checks order and content of every delivered codeword.
module tb_ecc_107_enc_fault_detc;

  logic         clk = 1'b0;
  logic         rst;
  logic         ecc_fault_detc_en;
  logic         bypass;
  logic         in_valid;
  logic         in_ready;
  logic [106:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [106:0] data_out;
  logic [7:0]   parity_out;
  logic         ecc_fault;
  logic         ecc_fatal;
  logic         fault_clr;
  logic [7:0]   fault_cnt;
`ifdef ECC_ERR_INJ_EN
  logic         inj_en;
  logic [114:0] inj_mask;
`endif

  always #5 clk = ~clk;

  ecc_107_enc_fault_detc dut (
    .clk              (clk),
    .rst              (rst),
    .ecc_fault_detc_en(ecc_fault_detc_en),
    .bypass           (bypass),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .data_in          (data_in),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .data_out         (data_out),
    .parity_out       (parity_out),
    .ecc_fault        (ecc_fault),
    .ecc_fatal        (ecc_fatal),
    .fault_clr        (fault_clr),
`ifdef ECC_ERR_INJ_EN
    .inj_en           (inj_en),
    .inj_mask         (inj_mask),
`endif
    .fault_cnt        (fault_cnt)
  );

  typedef struct {
    logic [106:0] data;
    logic         byp;
    logic [7:0]   par;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];
  vec_t cur_exp;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_pulse;
  logic last_acc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    data_in  = v.data;
    bypass   = v.byp;
    cur_exp  = v;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock: sample handshakes just before the edge, score outputs, then
  // return 1 time unit after the edge.
  task automatic cycle();
    vec_t e;
    #1;
    last_acc = in_valid && in_ready;
    if (ecc_fault) n_pulse++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got data %0h parity %0h with nothing pending", data_out, parity_out);
      end else begin
        e = sb.pop_front();
        check("out_data", data_out, e.data);
        check("out_parity", parity_out, e.par);
      end
    end
    if (last_acc) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    logic [106:0] held;

    vecs[0] = '{107'h0, 1'b0, 8'h00};
    vecs[1] = '{107'h1, 1'b0, 8'h83};
    vecs[2] = '{107'h2, 1'b0, 8'h85};
    vecs[3] = '{107'h4, 1'b0, 8'h86};
    vecs[4] = '{107'h3, 1'b0, 8'h06};
    vecs[5] = '{{1'b1, 106'h0}, 1'b0, 8'hF2};
    vecs[6] = '{{1'b1, 105'h0, 1'b1}, 1'b0, 8'h71};
    vecs[7] = '{{107{1'b1}}, 1'b1, 8'h00};

    rst = 1'b1; ecc_fault_detc_en = 1'b1; bypass = 1'b0; in_valid = 1'b0;
    data_in = '0; out_ready = 1'b1; fault_clr = 1'b0; n_pulse = 0;
`ifdef ECC_ERR_INJ_EN
    inj_en = 1'b0; inj_mask = '0;
`endif

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_parity_out", parity_out, 0);
    check("rst_ecc_fault", ecc_fault, 0);
    check("rst_ecc_fatal", ecc_fatal, 0);
    check("rst_fault_cnt", fault_cnt, 0);
    check("rst_in_ready_after", in_ready, 1);

    // Back-to-back 0 then 1: latency 2, no bubbles
    drive(vecs[0]); cycle();
    check("b2b_acc0", last_acc, 1);
    check("b2b_lat_not_yet", out_valid, 0);
    drive(vecs[1]); cycle();
    check("b2b_acc1", last_acc, 1);
    check("b2b_valid0", out_valid, 1);
    check("b2b_parity0", parity_out, 8'h00);
    idle(); cycle();
    check("b2b_valid1", out_valid, 1);
    check("b2b_parity1", parity_out, 8'h83);
    cycle();
    check("b2b_drained", out_valid, 0);

    // Table-driven streaming, one beat per cycle
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]); cycle();
      check($sformatf("stream_acc%0d", i), last_acc, 1);
    end
    idle();
    repeat (3) cycle();
    check("stream_sb_empty", sb.size(), 0);

    // Backpressure: out_ready low for 5 cycles over 3 beats
    out_ready = 1'b0;
    drive(vecs[2]); cycle();
    check("bp_acc_a", last_acc, 1);
    drive(vecs[3]); cycle();
    check("bp_acc_b", last_acc, 1);
    held = data_out;
    check("bp_head", held, vecs[2].data);
    drive(vecs[4]); cycle();
    check("bp_acc_c_blocked", last_acc, 0);
    cycle(); cycle();
    check("bp_in_ready_low", in_ready, 0);
    check("bp_data_stable", data_out, held);
    check("bp_parity_stable", parity_out, vecs[2].par);
    out_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      cycle();
      done = last_acc;
    end
    check("bp_accept_c", done, 1);
    idle();
    repeat (4) cycle();
    check("bp_sb_empty", sb.size(), 0);

    // Single-cycle u1 fault: one pulse, count 1, clean codeword one cycle late
    drive(vecs[1]); cycle();
    idle();
    force dut.par_u1 = 8'h82;
    cycle();
    release dut.par_u1;
    check("sf_pulse", ecc_fault, 1);
    check("sf_cnt", fault_cnt, 1);
    check("sf_out_wait", out_valid, 0);
    check("sf_in_ready", in_ready, 0);
    cycle();
    check("sf_pulse_end", ecc_fault, 0);
    check("sf_out_valid", out_valid, 1);
    check("sf_parity", parity_out, 8'h83);
    check("sf_fatal", ecc_fatal, 0);
    repeat (2) cycle();
    check("sf_sb_empty", sb.size(), 0);

    // Persistent fault: 1 + MAX_RETRY pulses, halt, then fault_clr
    drive(vecs[5]); cycle();
    force dut.par_u1 = 8'h0D;
    n_pulse = 0;
    drive(vecs[0]);
    repeat (8) cycle();
    check("pf_pulses", n_pulse, 4);
    check("pf_fatal", ecc_fatal, 1);
    check("pf_in_ready", in_ready, 0);
    check("pf_cnt", fault_cnt, 5);
    check("pf_no_out", out_valid, 0);
    idle();
    release dut.par_u1;
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    #1;
    check("clr_fatal", ecc_fatal, 0);
    check("clr_cnt", fault_cnt, 0);
    check("clr_in_ready", in_ready, 1);
    // The beat held at halt is discarded by fault_clr.
    if (sb.size() > 0) void'(sb.pop_back());
    repeat (3) cycle();
    check("clr_no_out", out_valid, 0);

    // Detection disabled: mismatching u1 ignored, u0 parity used
    ecc_fault_detc_en = 1'b0;
    force dut.par_u1 = 8'hFF;
    n_pulse = 0;
    drive(vecs[1]); cycle();
    drive(vecs[6]); cycle();
    idle();
    repeat (4) cycle();
    release dut.par_u1;
    ecc_fault_detc_en = 1'b1;
    check("dis_pulses", n_pulse, 0);
    check("dis_cnt", fault_cnt, 0);
    check("dis_sb_empty", sb.size(), 0);

`ifdef ECC_ERR_INJ_EN
    // One-shot injection: first load flipped, second clean
    inj_en = 1'b1;
    inj_mask = 115'h1;
    drive(vecs[0]); cur_exp = '{107'h1, 1'b0, 8'h00}; cycle();
    drive(vecs[0]); cycle();
    idle();
    repeat (4) cycle();
    inj_en = 1'b0;
    check("inj_sb_empty", sb.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
